// File: rtl/icache_data_ram_nway_pkg.sv
// icache_data_ram_nway_pkg
//   Shared definitions for the instruction-cache data store and its refill
//   engine: refill FSM state type, default geometry, the initial word
//   (a RISC-V NOP), and a constant clog2 helper for deriving field widths.
package icache_data_ram_nway_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } fill_state_e;

  localparam int unsigned DEF_NUM_WAYS       = 2;
  localparam int unsigned DEF_NUM_SETS       = 64;
  localparam int unsigned DEF_WORDS_PER_LINE = 4;
  localparam int unsigned DEF_DATA_WIDTH     = 32;
  localparam logic [31:0] DEF_INIT_WORD      = 32'h0000_0013;

  // Smallest r such that 2**r >= value (0 for value <= 1).
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((64'd1 << result) < 64'(value)) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/icache_data_ram_nway_refill_ctrl.sv
// icache_refill_ctrl
//   Refill engine for the icache data store. Accepts a critical-word-first
//   burst and turns each accepted beat into a write strobe/address/data
//   for the storage array.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   fill_start               begin refill (honoured only when idle)
//   fill_index/way/offset    set, victim way, critical word offset
//   fill_valid, fill_data    beat handshake and payload
//   fill_abort               cancel an in-progress refill
//   fill_ready/busy/done     handshake ready, refill active, completion pulse
//   wr_en/way/index/offset/data  write port towards the storage array
module icache_refill_ctrl
  import icache_data_ram_nway_pkg::*;
#(
  parameter  int unsigned NUM_WAYS       = DEF_NUM_WAYS,
  parameter  int unsigned NUM_SETS       = DEF_NUM_SETS,
  parameter  int unsigned WORDS_PER_LINE = DEF_WORDS_PER_LINE,
  parameter  int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
  localparam int unsigned IDX_W          = clog2(NUM_SETS),
  localparam int unsigned OFF_W          = clog2(WORDS_PER_LINE),
  localparam int unsigned WAY_W          = (clog2(NUM_WAYS) > 1) ? clog2(NUM_WAYS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fill_start,
  input  logic [IDX_W-1:0]      fill_index,
  input  logic [WAY_W-1:0]      fill_way,
  input  logic [OFF_W-1:0]      fill_offset,
  input  logic                  fill_valid,
  input  logic [DATA_WIDTH-1:0] fill_data,
  input  logic                  fill_abort,
  output logic                  fill_ready,
  output logic                  fill_busy,
  output logic                  fill_done,
  output logic                  wr_en,
  output logic [WAY_W-1:0]      wr_way,
  output logic [IDX_W-1:0]      wr_index,
  output logic [OFF_W-1:0]      wr_offset,
  output logic [DATA_WIDTH-1:0] wr_data
);

  fill_state_e      state;
  logic [OFF_W-1:0] cur_off;
  logic [OFF_W-1:0] beat_cnt;

  // An abort in the same cycle as a valid beat suppresses the write.
  assign wr_en     = (state == ST_FILL) && fill_valid && !fill_abort;
  assign wr_offset = cur_off;
  assign wr_data   = fill_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      fill_ready <= 1'b0;
      fill_busy  <= 1'b0;
      fill_done  <= 1'b0;
      wr_way     <= '0;
      wr_index   <= '0;
      cur_off    <= '0;
      beat_cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (fill_start) begin
            state      <= ST_FILL;
            fill_ready <= 1'b1;
            fill_busy  <= 1'b1;
            wr_way     <= fill_way;
            wr_index   <= fill_index;
            cur_off    <= fill_offset;
            beat_cnt   <= '0;
          end
        end
        ST_FILL: begin
          if (fill_abort) begin
            state      <= ST_IDLE;
            fill_ready <= 1'b0;
            fill_busy  <= 1'b0;
          end else if (fill_valid) begin
            // OFF_W-bit arithmetic gives the wrap-around for free.
            cur_off  <= cur_off + OFF_W'(1);
            beat_cnt <= beat_cnt + OFF_W'(1);
            if (beat_cnt == OFF_W'(WORDS_PER_LINE - 1)) begin
              state      <= ST_DONE;
              fill_ready <= 1'b0;
              fill_done  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state     <= ST_IDLE;
          fill_busy <= 1'b0;
          fill_done <= 1'b0;
        end
        default: begin
          state      <= ST_IDLE;
          fill_ready <= 1'b0;
          fill_busy  <= 1'b0;
          fill_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/icache_data_ram_nway.sv
// icache_data_ram_nway
//   N-way set-associative instruction-cache data store. Synchronous read of
//   the addressed word from every way in parallel (1-cycle latency), plus an
//   integrated critical-word-first refill engine.
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   rd_req, rd_index, rd_offset    read request and address
//   rd_valid, rd_data              registered read result, way w in lane w
//   fill_*                         refill handshake (see icache_refill_ctrl)
module icache_data_ram_nway
  import icache_data_ram_nway_pkg::*;
#(
  parameter  int unsigned NUM_WAYS       = DEF_NUM_WAYS,
  parameter  int unsigned NUM_SETS       = DEF_NUM_SETS,
  parameter  int unsigned WORDS_PER_LINE = DEF_WORDS_PER_LINE,
  parameter  int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter  logic [DATA_WIDTH-1:0] INIT_WORD = DATA_WIDTH'(DEF_INIT_WORD),
  localparam int unsigned IDX_W          = clog2(NUM_SETS),
  localparam int unsigned OFF_W          = clog2(WORDS_PER_LINE),
  localparam int unsigned WAY_W          = (clog2(NUM_WAYS) > 1) ? clog2(NUM_WAYS) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           rd_req,
  input  logic [IDX_W-1:0]               rd_index,
  input  logic [OFF_W-1:0]               rd_offset,
  output logic                           rd_valid,
  output logic [NUM_WAYS*DATA_WIDTH-1:0] rd_data,
  input  logic                           fill_start,
  input  logic [IDX_W-1:0]               fill_index,
  input  logic [WAY_W-1:0]               fill_way,
  input  logic [OFF_W-1:0]               fill_offset,
  input  logic                           fill_valid,
  input  logic [DATA_WIDTH-1:0]          fill_data,
  output logic                           fill_ready,
  input  logic                           fill_abort,
  output logic                           fill_busy,
  output logic                           fill_done
);

  localparam int unsigned DEPTH = NUM_WAYS * NUM_SETS * WORDS_PER_LINE;

  logic                           wr_en;
  logic [WAY_W-1:0]               wr_way;
  logic [IDX_W-1:0]               wr_index;
  logic [OFF_W-1:0]               wr_offset;
  logic [DATA_WIDTH-1:0]          wr_data;
  logic [NUM_WAYS*DATA_WIDTH-1:0] rd_next;

  // Declaration initialiser gives simulation-time NOP content; storage has no reset.
  logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: INIT_WORD};

  icache_refill_ctrl #(
    .NUM_WAYS      (NUM_WAYS),
    .NUM_SETS      (NUM_SETS),
    .WORDS_PER_LINE(WORDS_PER_LINE),
    .DATA_WIDTH    (DATA_WIDTH)
  ) u_refill_ctrl (
    .clk        (clk),
    .rst        (rst),
    .fill_start (fill_start),
    .fill_index (fill_index),
    .fill_way   (fill_way),
    .fill_offset(fill_offset),
    .fill_valid (fill_valid),
    .fill_data  (fill_data),
    .fill_abort (fill_abort),
    .fill_ready (fill_ready),
    .fill_busy  (fill_busy),
    .fill_done  (fill_done),
    .wr_en      (wr_en),
    .wr_way     (wr_way),
    .wr_index   (wr_index),
    .wr_offset  (wr_offset),
    .wr_data    (wr_data)
  );

  // Flattened address is {way, index, offset}.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[{wr_way, wr_index, wr_offset}] <= wr_data;
    end
  end

  // Write-first: a same-cycle beat to the read address forwards into its lane.
  always_comb begin
    rd_next = '0;
    for (int unsigned w = 0; w < NUM_WAYS; w++) begin
      if (wr_en && (wr_way == WAY_W'(w)) && (wr_index == rd_index) &&
          (wr_offset == rd_offset)) begin
        rd_next[w*DATA_WIDTH +: DATA_WIDTH] = wr_data;
      end else begin
        rd_next[w*DATA_WIDTH +: DATA_WIDTH] = mem[{WAY_W'(w), rd_index, rd_offset}];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_req;
      if (rd_req) begin
        rd_data <= rd_next;
      end
    end
  end

endmodule
